// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM states and widths for the HI/LO multiply/divide unit
package mdu_pkg;
   localparam int WORD  = 32;
   localparam int DWORD = 64;
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_t;
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative restoring divider, one quotient bit per step
// Ports: clk, rst; load latches dividend/divisor and clears the remainder;
// step performs one shift/trial-subtract; quo/rem expose the unsigned result.
module mdu_div_core
   import mdu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [WORD-1:0] dividend,
   input  logic [WORD-1:0] divisor,
   output logic [WORD-1:0] quo,
   output logic [WORD-1:0] rem
);
   logic [WORD-1:0] r, q, dv;
   logic [WORD:0]   t, d;
   assign t   = {r, q[WORD-1]};
   // bit WORD of the 33-bit difference is the borrow: set means restore
   assign d   = t - {1'b0, dv};
   assign quo = q;
   assign rem = r;
   always_ff @(posedge clk) begin
      if (rst) begin
         r  <= '0;
         q  <= '0;
         dv <= '0;
      end else if (load) begin
         r  <= '0;
         q  <= dividend;
         dv <= divisor;
      end else if (step) begin
         r <= d[WORD] ? t[WORD-1:0] : d[WORD-1:0];
         q <= {q[WORD-2:0], ~d[WORD]};
      end
   end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO
// Ports: clk, rst (sync, active high); start qualifies op/a/b; flush aborts
// any in-flight op; busy = state != IDLE; done pulses in the cycle HI/LO take
// a mul/div result; hi/lo are the architectural registers.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_ITERS  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [WORD-1:0] a,
   input  logic [WORD-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [WORD-1:0] hi,
   output logic [WORD-1:0] lo
);
   state_t           state, state_n;
   logic [4:0]       cnt, cnt_n;
   logic [DWORD-1:0] prod, sa, sb;
   logic [WORD-1:0]  hi_n, lo_n, quo, rem, dvd, dvs;
   logic             sign_q, sign_r, accept, is_mul, is_div, sgn, dz, load, step;
   assign is_mul = op == OP_MULT || op == OP_MULTU;
   assign is_div = op == OP_DIV || op == OP_DIVU;
   assign sgn    = op == OP_MULT || op == OP_DIV;
   assign dz     = b == '0;
   assign accept = state == IDLE && start && !flush;
   assign busy   = state != IDLE;
   assign sa     = {{WORD{sgn & a[WORD-1]}}, a};
   assign sb     = {{WORD{sgn & b[WORD-1]}}, b};
   // divide by zero: feed the raw dividend unsigned against a zero divisor;
   // every trial subtract then succeeds, giving quo=all ones and rem=a
   assign dvd    = dz ? a : (sgn && a[WORD-1]) ? -a : a;
   assign dvs    = (sgn && b[WORD-1]) ? -b : b;
   mdu_div_core u_div (
      .clk(clk), .rst(rst), .load(load), .step(step),
      .dividend(dvd), .divisor(dvs), .quo(quo), .rem(rem)
   );
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hi_n    = hi;
      lo_n    = lo;
      done    = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      if (flush) state_n = IDLE;
      else case (state)
         IDLE: if (start) begin
            if (op == OP_MTHI) hi_n = a;
            else if (op == OP_MTLO) lo_n = a;
            else if (is_mul) begin
               state_n = MUL;
               cnt_n   = 5'(MUL_CYCLES - 1);
            end else if (is_div) begin
               state_n = DIV;
               cnt_n   = 5'(DIV_ITERS - 1);
               load    = 1'b1;
            end
         end
         MUL: begin
            cnt_n   = cnt == '0 ? cnt : cnt - 5'd1;
            state_n = cnt == '0 ? IDLE : MUL;
            done    = cnt == '0;
            if (cnt == '0) {hi_n, lo_n} = prod;
         end
         DIV: begin
            step    = 1'b1;
            cnt_n   = cnt == '0 ? cnt : cnt - 5'd1;
            state_n = cnt == '0 ? FIX : DIV;
         end
         default: begin
            lo_n    = sign_q ? -quo : quo;
            hi_n    = sign_r ? -rem : rem;
            done    = 1'b1;
            state_n = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         prod   <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hi    <= hi_n;
         lo    <= lo_n;
         if (accept && is_mul) prod <= sa * sb;
         if (accept && is_div) begin
            sign_q <= sgn && !dz && (a[WORD-1] ^ b[WORD-1]);
            sign_r <= sgn && !dz && a[WORD-1];
         end
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
   import mdu_pkg::*;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [31:0] hi, lo;
   int          checks = 0, errors = 0;
   mul_div_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );
   always #5 clk = ~clk;
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_idle(output int cyc, output int dn);
      cyc = 0; dn = 0;
      while (busy && cyc < 200) begin
         if (done) dn++;
         cyc++;
         @(negedge clk);
      end
   endtask
   task automatic expect_result(input string name, input int cyc, input int dn,
                                input int ecyc, input logic [31:0] ehi, input logic [31:0] elo);
      checks++;
      if (cyc != ecyc) begin errors++; $display("FAIL %s_busy_cycles got %0d exp %0d", name, cyc, ecyc); end
      checks++;
      if (dn != 1) begin errors++; $display("FAIL %s_done_pulses got %0d exp 1", name, dn); end
      checks++;
      if (hi !== ehi) begin errors++; $display("FAIL %s_hi got %h exp %h", name, hi, ehi); end
      checks++;
      if (lo !== elo) begin errors++; $display("FAIL %s_lo got %h exp %h", name, lo, elo); end
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++; $display("FAIL reset got busy=%b done=%b hi=%h lo=%h exp all zero", busy, done, hi, lo);
      end
   endtask
   task automatic test_mul;
      int cyc, dn;
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle(cyc, dn);
      expect_result("multu", cyc, dn, 2, 32'hFFFFFFFE, 32'h00000001);
      issue(OP_MULT, 32'hFFFFFFFF, 32'h00000001);
      wait_idle(cyc, dn);
      expect_result("mult", cyc, dn, 2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(OP_MULT, 32'hFFFFFFFD, 32'h00000005);
      wait_idle(cyc, dn);
      expect_result("mult_neg", cyc, dn, 2, 32'hFFFFFFFF, 32'hFFFFFFF1);
   endtask
   task automatic test_div;
      int cyc, dn;
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_idle(cyc, dn);
      expect_result("div_neg", cyc, dn, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_idle(cyc, dn);
      expect_result("divu", cyc, dn, 33, 32'd2, 32'd14);
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(cyc, dn);
      expect_result("div_ovf", cyc, dn, 33, 32'd0, 32'h80000000);
   endtask
   task automatic test_div_zero;
      int cyc, dn;
      issue(OP_DIVU, 32'h12345678, 32'd0);
      wait_idle(cyc, dn);
      expect_result("divu_zero", cyc, dn, 33, 32'h12345678, 32'hFFFFFFFF);
      issue(OP_DIV, 32'hFFFFFFF0, 32'd0);
      wait_idle(cyc, dn);
      expect_result("div_zero_neg", cyc, dn, 33, 32'hFFFFFFF0, 32'hFFFFFFFF);
   endtask
   task automatic test_mthi_mtlo;
      issue(OP_MTHI, 32'hAAAA0000, 32'd0);
      issue(OP_MTLO, 32'h5555AAAA, 32'd0);
      checks++;
      if (hi !== 32'hAAAA0000) begin errors++; $display("FAIL mthi got %h exp %h", hi, 32'hAAAA0000); end
      checks++;
      if (lo !== 32'h5555AAAA) begin errors++; $display("FAIL mtlo got %h exp %h", lo, 32'h5555AAAA); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b exp 0", busy); end
   endtask
   task automatic test_flush;
      int dn = 0;
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b exp 1", busy); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
      for (int i = 0; i < 40; i++) begin
         if (done || busy) dn++;
         @(negedge clk);
      end
      checks++;
      if (dn != 0) begin errors++; $display("FAIL flush_no_done got %0d active cycles exp 0", dn); end
      checks++;
      if (hi !== 32'hAAAA0000) begin errors++; $display("FAIL flush_hi got %h exp %h", hi, 32'hAAAA0000); end
      checks++;
      if (lo !== 32'h5555AAAA) begin errors++; $display("FAIL flush_lo got %h exp %h", lo, 32'h5555AAAA); end
      flush = 1'b1;
      issue(OP_MTLO, 32'h12341234, 32'd0);
      flush = 1'b0;
      checks++;
      if (lo !== 32'h5555AAAA) begin errors++; $display("FAIL flush_mtlo got %h exp %h", lo, 32'h5555AAAA); end
      flush = 1'b1;
      issue(OP_MULTU, 32'd3, 32'd3);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_mul_busy got %b exp 0", busy); end
   endtask
   task automatic test_busy_start;
      int cyc, dn;
      issue(OP_MULTU, 32'd3, 32'd5);
      start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_start_mid got %b exp 1", busy); end
      wait_idle(cyc, dn);
      expect_result("busy_start", cyc + 1, dn, 2, 32'd0, 32'd15);
   endtask
   task automatic test_rst_mid;
      issue(OP_DIV, 32'd1000, 32'd3);
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, hi, lo} !== 65'd0) begin
         errors++; $display("FAIL rst_mid got busy=%b hi=%h lo=%h exp all zero", busy, hi, lo);
      end
      repeat (40) @(negedge clk);
      checks++;
      if ({busy, hi, lo} !== 65'd0) begin
         errors++; $display("FAIL rst_mid_late got busy=%b hi=%h lo=%h exp all zero", busy, hi, lo);
      end
      @(negedge clk);
   endtask
   initial begin
      @(negedge clk);
      test_reset;
      test_mul;
      test_div;
      test_div_zero;
      test_mthi_mtlo;
      test_flush;
      test_busy_start;
      test_rst_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
